// File: rtl/disp_share_arbiter.sv
// Round-robin arbiter that time-shares the 4-digit hex display among NSRC requesters,
// holding each owner for a minimum dwell. Define DISP_ARB_PRIO_EN to make source 0 pre-empting.
module disp_share_arbiter #(
  parameter int NSRC        = 4,
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NSRC-1:0]         req,
  input  logic [NSRC*16-1:0]      data_flat,
  input  logic [NSRC*4-1:0]       dp_flat,
  output logic [3:0]              hex3,
  output logic [3:0]              hex2,
  output logic [3:0]              hex1,
  output logic [3:0]              hex0,
  output logic [3:0]              dp_out,
  output logic [$clog2(NSRC)-1:0] owner,
  output logic [NSRC-1:0]         grant,
  output logic                    busy
);
  localparam int TW = $clog2(HOLD_CYCLES);
  localparam int OW = $clog2(NSRC);
  localparam logic [TW-1:0] TIMER_MAX = TW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARB, SHOW} state_t;

  state_t          state;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] pend_next;
  logic [NSRC-1:0] grant_next;
  logic [TW-1:0]   timer;
  logic [OW-1:0]   rr_pick;
  logic [OW-1:0]   pick;
  logic            rr_found;
  logic            preempt;
  logic [15:0]     own_data;
  logic [3:0]      own_dp;

  // Search owner+1, owner+2, ... wrapping, so the current owner is considered last.
  always_comb begin : rr_search
    logic [OW:0]   sum;
    logic [OW-1:0] cand;
    // NOTE: every always_comb target is given a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    rr_pick  = owner;
    rr_found = 1'b0;
    sum      = '0;
    cand     = '0;
    for (int k = 1; k <= NSRC; k++) begin
      sum = {1'b0, owner} + (OW+1)'(k);
      if (sum >= (OW+1)'(NSRC)) sum = sum - (OW+1)'(NSRC);
      cand = sum[OW-1:0];
      if (!rr_found && pend[cand]) begin
        rr_pick  = cand;
        rr_found = 1'b1;
      end
    end
  end

`ifdef DISP_ARB_PRIO_EN
  // Source 0 jumps the queue only while someone else owns the display.
  assign preempt = pend[0] && (owner != '0);
`else
  assign preempt = 1'b0;
`endif

  assign pick     = preempt ? '0 : rr_pick;
  assign own_data = data_flat[int'(owner)*16 +: 16];
  assign own_dp   = dp_flat[int'(owner)*4 +: 4];

  always_comb begin
    grant_next = '0;
    if (state == ARB && (rr_found || preempt)) grant_next[pick] = 1'b1;
  end

  // A request arriving in its own grant cycle survives the clear and is re-queued.
  assign pend_next = req | (pend & ~grant_next);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                  <= IDLE;
      pend                   <= '0;
      timer                  <= '0;
      owner                  <= '0;
      grant                  <= '0;
      busy                   <= 1'b0;
      {hex3, hex2, hex1, hex0} <= '0;
      dp_out                 <= 4'hF;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // the pre-edge values, independent of statement order in this block.
      pend  <= pend_next;
      grant <= grant_next;
      busy  <= |pend_next;
      if (state != IDLE) begin
        {hex3, hex2, hex1, hex0} <= own_data;
        dp_out                 <= own_dp;
      end
      unique case (state)
        IDLE: if (pend != '0) state <= ARB;
        ARB: begin
          owner <= pick;
          timer <= '0;
          state <= SHOW;
        end
        SHOW: begin
          if (timer != TIMER_MAX) timer <= timer + 1'b1;
          if (preempt || (timer == TIMER_MAX && pend != '0)) state <= ARB;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_disp_share_arbiter.sv
// Self-checking bench for disp_share_arbiter (NSRC=4, HOLD_CYCLES=8): cycle table plus
// grant scoreboard holding expected source, owner and arrival cycle.
`timescale 1ns/1ps
module tb_disp_share_arbiter;
  localparam int NSRC = 4;
  localparam int HOLD = 8;
  localparam int GAP  = HOLD + 1;
`ifdef DISP_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NSRC-1:0]   req;
  logic [NSRC*16-1:0] data_flat;
  logic [NSRC*4-1:0] dp_flat;
  logic [3:0]        hex3, hex2, hex1, hex0, dp_out;
  logic [1:0]        owner;
  logic [NSRC-1:0]   grant;
  logic              busy;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  int unsigned cyc    = 0;

  typedef struct {
    logic [3:0]  vec;
    logic [1:0]  own;
    int unsigned cyc;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        busy;
    bit          chk_hex;
    logic [15:0] hex;
    logic [3:0]  dp;
  } vec_t;
  vec_t tbl[4];

  disp_share_arbiter #(.NSRC(NSRC), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .req(req), .data_flat(data_flat), .dp_flat(dp_flat),
    .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0), .dp_out(dp_out),
    .owner(owner), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_sb(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hex"},   32'({hex3, hex2, hex1, hex0}), 32'h0);
    check({tag, "_dp"},    32'(dp_out), 32'hF);
    check({tag, "_owner"}, 32'(owner), 32'd0);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  // Every grant pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && grant !== '0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_grant", 32'(grant), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("grant_vec",   32'(grant), 32'(e.vec));
        check("grant_owner", 32'(owner), 32'(e.own));
        check("grant_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned t0, g0, ta, g3, tb, g2, tc, tq, td;
    reset     = 1'b0;
    req       = '0;
    data_flat = {16'h9876, 16'hC0DE, 16'h1234, 16'h5A5A};
    dp_flat   = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b1;

    // Single request from idle: ARB, grant, then display switch.
    tbl[0] = '{4'b0100, 4'b0000, 2'd0, 1'b1, 1'b1, 16'h0000, 4'hF};
    tbl[1] = '{4'b0000, 4'b0000, 2'd0, 1'b1, 1'b1, 16'h0000, 4'hF};
    tbl[2] = '{4'b0000, 4'b0100, 2'd2, 1'b0, 1'b0, 16'h0000, 4'hF};
    tbl[3] = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1, 16'hC0DE, 4'b1011};
    t0 = cyc;
    g0 = t0 + 3;
    sb_q.push_back('{4'b0100, 2'd2, g0});
    for (int i = 0; i < 4; i++) begin
      req = tbl[i].req;
      tick();
      check($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].grant));
      check($sformatf("tbl%0d_owner", i), 32'(owner), 32'(tbl[i].owner));
      check($sformatf("tbl%0d_busy", i),  32'(busy),  32'(tbl[i].busy));
      if (tbl[i].chk_hex) begin
        check($sformatf("tbl%0d_hex", i), 32'({hex3, hex2, hex1, hex0}), 32'(tbl[i].hex));
        check($sformatf("tbl%0d_dp", i),  32'(dp_out), 32'(tbl[i].dp));
      end
    end

    // Three simultaneous requests during owner 2's dwell: order 3, 0, 1, 9 clk apart.
    sb_q.push_back('{4'b1000, 2'd3, g0 + GAP});
    sb_q.push_back('{4'b0001, 2'd0, g0 + 2*GAP});
    sb_q.push_back('{4'b0010, 2'd1, g0 + 3*GAP});
    req = 4'b1011;
    tick();
    req = '0;
    wait_sb(50);

    // Owner 1 keeps the display when nothing is pending; 1-clk data latency.
    tick(30);
    check("idle_owner", 32'(owner), 32'd1);
    check("idle_busy",  32'(busy),  32'd0);
    check("idle_hex",   32'({hex3, hex2, hex1, hex0}), 32'h1234);
    check("idle_dp",    32'(dp_out), 32'b1101);
    data_flat[31:16] = 16'hABCD;
    #1;
    check("hex_before_edge", 32'({hex3, hex2, hex1, hex0}), 32'h1234);
    tick();
    check("hex_after_edge",  32'({hex3, hex2, hex1, hex0}), 32'hABCD);

    // Re-request in the grant cycle: set wins, source 3 granted again after the dwell.
    ta = cyc;
    g3 = ta + 3 + GAP;
    sb_q.push_back('{4'b1000, 2'd3, ta + 3});
    sb_q.push_back('{4'b1000, 2'd3, g3});
    req = 4'b1000;
    tick();
    req = '0;
    tick();
    req = 4'b1000;
    tick();
    req = '0;
    check("setwins_busy", 32'(busy), 32'd1);
    wait_sb(30);
    check("requeue_busy",  32'(busy),  32'd0);
    check("requeue_owner", 32'(owner), 32'd3);

    // Asynchronous reset mid-dwell of owner 2 drops the pending request of source 1.
    tb = cyc;
    g2 = (g3 + GAP > tb + 3) ? g3 + GAP : tb + 3;
    sb_q.push_back('{4'b0100, 2'd2, g2});
    req = 4'b0100;
    tick();
    req = '0;
    wait_sb(30);
    while (cyc < g2 + 4) begin
      req = (cyc == g2 + 2) ? 4'b0010 : 4'b0000;
      tick();
    end
    req = '0;
    check("pre_reset_owner", 32'(owner), 32'd2);
    check("pre_reset_busy",  32'(busy),  32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("async_reset");
    @(negedge clk);
    reset = 1'b1;
    tick(12);
    check_reset_vals("post_reset");

    // Source 0 request while owner 3 is at timer 2.
    tc = cyc;
    sb_q.push_back('{4'b1000, 2'd3, tc + 3});
    req = 4'b1000;
    tick();
    req = '0;
    tick(4);
    tq = cyc;
    sb_q.push_back('{4'b0001, 2'd0, PRIO ? tq + 3 : tq + 7});
    req = 4'b0001;
    tick();
    req = '0;
    wait_sb(20);
    tick(2);
    check("src0_hex", 32'({hex3, hex2, hex1, hex0}), 32'h5A5A);
    check("src0_dp",  32'(dp_out), 32'b1110);

    // After reset the search starts at source 1, source 0 comes last.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    td = cyc;
    sb_q.push_back('{4'b0010, 2'd1, td + 3});
    sb_q.push_back('{4'b0001, 2'd0, PRIO ? td + 5 : td + 3 + GAP});
    req = 4'b0011;
    tick();
    req = '0;
    wait_sb(20);
    check("final_owner", 32'(owner), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
